seq_dtree_engine: RTL and testbench
===================================

SEQ_DTREE_ENGINE -- requirements
Module: seq_dtree_engine

Interface
REQ-001 SHALL have parameter N_FEAT, default 18: number of input features.
REQ-002 SHALL have parameter FW, default 8: feature and threshold width in bits.
REQ-003 SHALL have parameter N_NODES, default 64: node-table depth; NA = clog2(N_NODES).
REQ-004 SHALL have parameter CW, default 2: class-label width.
REQ-005 SHALL have parameter DEPTH_MAX, default 16: maximum internal nodes visited per inference.
REQ-006 SHALL use node word layout, MSB to LSB: leaf(1), feat(FI=clog2(N_FEAT)), shift(SW=clog2(FW)), thr(FW), left(NA), right(NA); NW = total width.
REQ-007 clk  input  1  sole clock, all state updates on rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 cfg_we  input  1  node-table write strobe.
REQ-010 cfg_addr  input  NA  node index to write.
REQ-011 cfg_wdata  input  NW  node word.
REQ-012 cfg_busy  output  1  high when not IDLE; writes dropped while high.
REQ-013 in_valid  input  1  feature vector valid.
REQ-014 in_ready  output  1  engine accepts a vector.
REQ-015 in_feats  input  N_FEAT*FW  flat features; feature i at bits [i*FW +: FW].
REQ-016 out_valid  output  1  result valid.
REQ-017 out_ready  input  1  consumer accepts result.
REQ-018 out_class  output  CW  predicted class.
REQ-019 out_err  output  1  inference aborted (depth overrun or bad feature index).
REQ-020 out_depth  output  clog2(DEPTH_MAX+1)  internal nodes visited.

Function
REQ-021 SHALL implement FSM states IDLE, WALK, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-022 IDLE: on in_valid&&in_ready, SHALL register in_feats, set ptr=0, depth=0, go WALK.
REQ-023 WALK: each cycle SHALL evaluate exactly one node, node[ptr].
REQ-024 Internal node: SHALL compute (feats[feat] >> shift) <= thr, unsigned, full FW-bit compare; true -> ptr=left, false -> ptr=right; depth+1.
REQ-025 Leaf node: SHALL load out_class = thr[CW-1:0], out_err=0, go DONE; depth unchanged.
REQ-026 Latency: result valid the cycle after the edge evaluating the leaf; n nodes visited -> out_valid rises n+1 edges after accept edge.
REQ-027 Internal node with depth==DEPTH_MAX already SHALL abort: out_class=0, out_err=1, go DONE.
REQ-028 Internal node with feat >= N_FEAT SHALL abort: out_class=0, out_err=1, go DONE.
REQ-029 DONE: outputs SHALL hold stable until out_valid&&out_ready, then go IDLE; no new accept in same cycle.
REQ-030 cfg_we in IDLE SHALL write node[cfg_addr] at that edge; cfg_we in WALK/DONE SHALL be ignored.
REQ-031 cfg_we coincident with an accept in IDLE SHALL complete the write; the new inference SHALL see the written word.
REQ-032 Child pointers SHALL wrap modulo N_NODES when N_NODES is not a power of two (index >= N_NODES reads node 0).
REQ-033 Registered features SHALL not change during WALK regardless of in_feats.

Reset
REQ-034 rst SHALL immediately force state=IDLE, ptr=0, depth=0, out_class=0, out_err=0, out_depth=0, out_valid=0, in_ready=1, cfg_busy=0.
REQ-035 rst SHALL clear every node word to all-zero (internal, feat 0, shift 0, thr 0, children 0).
REQ-036 rst asserted mid-WALK or mid-DONE SHALL discard the inference with no out_valid pulse.

Verification
REQ-037 Reset table, send any vector -> self-loop at node 0, out_valid after DEPTH_MAX+1 edges, out_err=1, out_class=0, out_depth=16.
REQ-038 node0={int,feat7,shift4,thr10,L1,R2}, node1=leaf class1, node2=leaf class3; X7=0xAF -> class1; X7=0xB0 -> class3; both out_depth=1, latency 2 edges.
REQ-039 Node0 feat=20 (>=18) -> out_err=1, out_class=0, out_depth=0 after 1 edge.
REQ-040 Hold out_ready=0 ten cycles in DONE -> outputs stable, in_ready=0, cfg_we writes dropped (readback via next inference unchanged).
REQ-041 Assert rst two cycles into a 5-node walk -> no out_valid, all outputs at reset values, table zeroed.
REQ-042 Back-to-back vectors with out_ready=1 -> each result exactly once, in order, one idle cycle between DONE and next accept.

Source files
------------

// File: rtl/seq_dtree_engine.sv
// Sequential decision-tree inference engine.
// A programmable node table is walked one node per clock: internal nodes compare a
// shifted feature against a threshold and branch, leaf nodes deliver the class label.
module seq_dtree_engine #(
    parameter int unsigned N_FEAT    = 18,
    parameter int unsigned FW        = 8,
    parameter int unsigned N_NODES   = 64,
    parameter int unsigned CW        = 2,
    parameter int unsigned DEPTH_MAX = 16,
    localparam int unsigned NA = $clog2(N_NODES),
    localparam int unsigned FI = $clog2(N_FEAT),
    localparam int unsigned SW = $clog2(FW),
    localparam int unsigned NW = 1 + FI + SW + FW + 2 * NA,
    localparam int unsigned DW = $clog2(DEPTH_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [NA-1:0]        cfg_addr,
    input  logic [NW-1:0]        cfg_wdata,
    output logic                 cfg_busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_FEAT*FW-1:0] in_feats,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_class,
    output logic                 out_err,
    output logic [DW-1:0]        out_depth
);

    typedef enum logic [1:0] {StIdle, StWalk, StDone} state_t;

    state_t        state_q, state_d;
    logic [NA-1:0] ptr_q, ptr_d;
    logic [DW-1:0] depth_q, depth_d;
    logic [CW-1:0] class_q, class_d;
    logic          err_q, err_d;
    logic          load_feats;

    logic [NW-1:0] nodes_q [N_NODES];
    logic [FW-1:0] feats_q [N_FEAT];

    // Current node decode
    logic [NA-1:0] rd_idx;
    logic [NW-1:0] node;
    logic          n_leaf;
    logic [FI-1:0] n_feat;
    logic [SW-1:0] n_shift;
    logic [FW-1:0] n_thr;
    logic [NA-1:0] n_left, n_right;
    logic [FW-1:0] feat_val;
    logic          feat_ok;
    logic          go_left;

    // Out-of-range child pointers fall back to node 0 on non-power-of-two tables
    if (N_NODES == (1 << NA)) begin : g_pow2
        assign rd_idx = ptr_q;
    end else begin : g_wrap
        assign rd_idx = (32'(ptr_q) < N_NODES) ? ptr_q : '0;
    end

    assign node    = nodes_q[rd_idx];
    assign n_leaf  = node[NW-1];
    assign n_feat  = node[NW-2 -: FI];
    assign n_shift = node[NW-2-FI -: SW];
    assign n_thr   = node[2*NA +: FW];
    assign n_left  = node[NA +: NA];
    assign n_right = node[0 +: NA];

    // Feature mux; feat_ok stays low for indices beyond the feature vector
    always_comb begin
        feat_val = '0;
        feat_ok  = 1'b0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (n_feat == FI'(i)) begin
                feat_val = feats_q[i];
                feat_ok  = 1'b1;
            end
        end
    end

    assign go_left = (feat_val >> n_shift) <= n_thr;

    // Next-state and datapath update for the walk
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        depth_d    = depth_q;
        class_d    = class_q;
        err_d      = err_q;
        load_feats = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    load_feats = 1'b1;
                    ptr_d      = '0;
                    depth_d    = '0;
                    state_d    = StWalk;
                end
            end
            StWalk: begin
                if (n_leaf) begin
                    class_d = n_thr[CW-1:0];
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if (depth_q == DW'(DEPTH_MAX) || !feat_ok) begin
                    class_d = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    ptr_d   = go_left ? n_left : n_right;
                    depth_d = depth_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            depth_q <= '0;
            class_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
            class_q <= class_d;
            err_q   <= err_d;
        end
    end

    // Feature capture; frozen for the whole walk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_FEAT; i++) feats_q[i] <= '0;
        end else if (load_feats) begin
            for (int i = 0; i < N_FEAT; i++) feats_q[i] <= in_feats[i*FW +: FW];
        end
    end

    // Node table; writable only while idle so a walk never sees a torn tree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NODES; i++) nodes_q[i] <= '0;
        end else if (cfg_we && state_q == StIdle) begin
            nodes_q[cfg_addr] <= cfg_wdata;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign cfg_busy  = (state_q != StIdle);
    assign out_class = class_q;
    assign out_err   = err_q;
    assign out_depth = depth_q;

endmodule

// File: tb/tb_seq_dtree_engine.sv
// Self-checking bench for seq_dtree_engine against a behavioural tree-walk model.
module tb_seq_dtree_engine;

    localparam int N_FEAT    = 18;
    localparam int FW        = 8;
    localparam int N_NODES   = 64;
    localparam int CW        = 2;
    localparam int DEPTH_MAX = 16;
    localparam int NA        = $clog2(N_NODES);
    localparam int FI        = $clog2(N_FEAT);
    localparam int SW        = $clog2(FW);
    localparam int NW        = 1 + FI + SW + FW + 2 * NA;
    localparam int DW        = $clog2(DEPTH_MAX + 1);
    localparam int FV        = N_FEAT * FW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we = 1'b0;
    logic [NA-1:0] cfg_addr = '0;
    logic [NW-1:0] cfg_wdata = '0;
    logic          cfg_busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FV-1:0] in_feats = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_class;
    logic          out_err;
    logic [DW-1:0] out_depth;

    int errors = 0;
    int checks = 0;

    logic [NW-1:0] mt [N_NODES];

    seq_dtree_engine dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_busy  (cfg_busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_feats  (in_feats),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_err   (out_err),
        .out_depth (out_depth)
    );

    always #5 clk = ~clk;

    function automatic logic [NW-1:0] mk(input int leaf, input int feat, input int shift,
                                         input int thr, input int l, input int r);
        return {1'(leaf), FI'(feat), SW'(shift), FW'(thr), NA'(l), NA'(r)};
    endfunction

    function automatic logic [FV-1:0] rand_feats();
        logic [FV-1:0] f;
        for (int i = 0; i < N_FEAT; i++) f[i*FW +: FW] = FW'($urandom);
        return f;
    endfunction

    // Reference walk straight from the tree rules; latency is d+1 edges after accept
    function automatic void ref_walk(input logic [FV-1:0] f, output int c, output int e,
                                     output int d);
        int p, feat, shift, thr, x;
        logic [NW-1:0] w;
        p = 0; d = 0; c = 0; e = 1;
        for (int k = 0; k <= DEPTH_MAX + 1; k++) begin
            w     = mt[p];
            feat  = int'(w[NW-2 -: FI]);
            shift = int'(w[NW-2-FI -: SW]);
            thr   = int'(w[2*NA +: FW]);
            if (w[NW-1]) begin
                c = thr % (1 << CW); e = 0; return;
            end
            if (d == DEPTH_MAX || feat >= N_FEAT) begin
                c = 0; e = 1; return;
            end
            x = int'(f[feat*FW +: FW]) >> shift;
            p = (x <= thr) ? int'(w[NA +: NA]) : int'(w[0 +: NA]);
            if (p >= N_NODES) p = 0;
            d++;
        end
    endfunction

    task automatic do_reset();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N_NODES; i++) mt[i] = '0;
    endtask

    task automatic cfg_write(input int a, input logic [NW-1:0] wd);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = NA'(a); cfg_wdata = wd;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        mt[a] = wd;
    endtask

    // Launch one vector (optionally with a coincident table write) and wait for the result
    task automatic infer(input logic [FV-1:0] f, input logic we, input int a,
                         input logic [NW-1:0] wd, output int c, output int e, output int d,
                         output int lat);
        @(negedge clk);
        in_valid = 1'b1; in_feats = f;
        cfg_we = we; cfg_addr = NA'(a); cfg_wdata = wd;
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0;
        lat = 1;
        @(posedge clk); #1;
        while (out_valid !== 1'b1 && lat < 200) begin
            in_feats = rand_feats();
            @(posedge clk); #1;
            lat++;
        end
        c = int'(out_class); e = int'(out_err); d = int'(out_depth);
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic build_example();
        cfg_write(0, mk(0, 7, 4, 10, 1, 2));
        cfg_write(1, mk(1, 0, 0, 1, 0, 0));
        cfg_write(2, mk(1, 0, 0, 3, 0, 0));
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({in_ready, out_valid, cfg_busy, out_class, out_err, out_depth} !==
            {1'b1, 1'b0, 1'b0, CW'(0), 1'b0, DW'(0)}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b cls=%0d err=%b dep=%0d, want 1 0 0 0 0 0",
                     in_ready, out_valid, cfg_busy, out_class, out_err, out_depth);
        end
    endtask

    task automatic test_zero_table();
        int c, e, d, lat;
        infer(rand_feats(), 1'b0, 0, '0, c, e, d, lat);
        checks++;
        if (c !== 0 || e !== 1 || d !== DEPTH_MAX || lat !== DEPTH_MAX + 1) begin
            errors++;
            $display("FAIL zero_table: got cls=%0d err=%0d dep=%0d lat=%0d, want 0 1 %0d %0d",
                     c, e, d, lat, DEPTH_MAX, DEPTH_MAX + 1);
        end
    endtask

    task automatic test_example();
        int c, e, d, lat;
        logic [FV-1:0] f;
        logic [7:0] xs [2];
        int want [2];
        xs[0] = 8'hAF; xs[1] = 8'hB0; want[0] = 1; want[1] = 3;
        build_example();
        for (int i = 0; i < 2; i++) begin
            f = rand_feats();
            f[7*FW +: FW] = xs[i];
            infer(f, 1'b0, 0, '0, c, e, d, lat);
            checks++;
            if (c !== want[i] || e !== 0 || d !== 1 || lat !== 2) begin
                errors++;
                $display("FAIL example_x%0h: got cls=%0d err=%0d dep=%0d lat=%0d, want %0d 0 1 2",
                         xs[i], c, e, d, lat, want[i]);
            end
        end
    endtask

    task automatic test_bad_feat();
        int c, e, d, lat;
        cfg_write(0, mk(0, 20, 0, 10, 1, 2));
        infer(rand_feats(), 1'b0, 0, '0, c, e, d, lat);
        checks++;
        if (c !== 0 || e !== 1 || d !== 0 || lat !== 1) begin
            errors++;
            $display("FAIL bad_feat: got cls=%0d err=%0d dep=%0d lat=%0d, want 0 1 0 1",
                     c, e, d, lat);
        end
    endtask

    task automatic test_random();
        int c, e, d, lat, ec, ee, ed, ft;
        logic [FV-1:0] f;
        for (int p = 0; p < N_NODES; p++) begin
            ft = ($urandom % 10 == 0) ? int'($urandom_range(18, 31)) : int'($urandom % 18);
            cfg_write(p, mk(($urandom % 3 == 0) ? 1 : 0, ft, $urandom % 8, $urandom % 256,
                            $urandom % N_NODES, $urandom % N_NODES));
        end
        for (int n = 0; n < 24; n++) begin
            f = rand_feats();
            ref_walk(f, ec, ee, ed);
            infer(f, 1'b0, 0, '0, c, e, d, lat);
            checks++;
            if (c !== ec || e !== ee || d !== ed || lat !== ed + 1) begin
                errors++;
                $display("FAIL random_%0d: got cls=%0d err=%0d dep=%0d lat=%0d, want %0d %0d %0d %0d",
                         n, c, e, d, lat, ec, ee, ed, ed + 1);
            end
        end
    endtask

    task automatic test_hold();
        int c, e, d, lat, ec, ee, ed;
        logic [FV-1:0] f;
        logic [CW+DW:0] snap;
        do_reset();
        build_example();
        f = rand_feats();
        f[7*FW +: FW] = 8'hAF;
        ref_walk(f, ec, ee, ed);
        out_ready = 1'b0;
        infer(f, 1'b0, 0, '0, c, e, d, lat);
        checks++;
        if (c !== ec || e !== ee || d !== ed || lat !== ed + 1) begin
            errors++;
            $display("FAIL hold_result: got cls=%0d err=%0d dep=%0d lat=%0d, want %0d %0d %0d %0d",
                     c, e, d, lat, ec, ee, ed, ed + 1);
        end
        snap = {out_class, out_err, out_depth};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, cfg_busy, out_class, out_err, out_depth} !==
                {1'b1, 1'b0, 1'b1, snap}) begin
                errors++;
                $display("FAIL hold_cycle_%0d: got vld=%b rdy=%b busy=%b res=%h, want 1 0 1 %h",
                         i, out_valid, in_ready, cfg_busy,
                         {out_class, out_err, out_depth}, snap);
            end
            cfg_we = 1'b1; cfg_addr = NA'(1); cfg_wdata = mk(1, 0, 0, 0, 0, 0);
            in_feats = rand_feats();
        end
        @(negedge clk);
        cfg_we = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got rdy=%b, want 1", in_ready);
        end
        infer(f, 1'b0, 0, '0, c, e, d, lat);
        checks++;
        if (c !== ec || e !== ee || d !== ed) begin
            errors++;
            $display("FAIL hold_write_dropped: got cls=%0d err=%0d dep=%0d, want %0d %0d %0d",
                     c, e, d, ec, ee, ed);
        end
    endtask

    task automatic test_cfg_with_accept();
        int c, e, d, lat;
        mt[0] = mk(1, 0, 0, 2, 0, 0);
        infer(rand_feats(), 1'b1, 0, mt[0], c, e, d, lat);
        checks++;
        if (c !== 2 || e !== 0 || d !== 0 || lat !== 1) begin
            errors++;
            $display("FAIL cfg_with_accept: got cls=%0d err=%0d dep=%0d lat=%0d, want 2 0 0 1",
                     c, e, d, lat);
        end
    endtask

    task automatic test_reset_midwalk();
        int c, e, d, lat, seen;
        for (int i = 0; i < 4; i++) cfg_write(i, mk(0, i, 0, 255, i + 1, i + 1));
        cfg_write(4, mk(1, 0, 0, 2, 0, 0));
        @(negedge clk);
        in_valid = 1'b1; in_feats = rand_feats();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, cfg_busy, out_class, out_err, out_depth} !==
            {1'b1, 1'b0, 1'b0, CW'(0), 1'b0, DW'(0)}) begin
            errors++;
            $display("FAIL midwalk_async_reset: got rdy=%b vld=%b busy=%b cls=%0d err=%b dep=%0d, want 1 0 0 0 0 0",
                     in_ready, out_valid, cfg_busy, out_class, out_err, out_depth);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N_NODES; i++) mt[i] = '0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midwalk_no_valid: got %0d valid cycles, want 0", seen);
        end
        infer(rand_feats(), 1'b0, 0, '0, c, e, d, lat);
        checks++;
        if (c !== 0 || e !== 1 || d !== DEPTH_MAX || lat !== DEPTH_MAX + 1) begin
            errors++;
            $display("FAIL midwalk_table_cleared: got cls=%0d err=%0d dep=%0d lat=%0d, want 0 1 %0d %0d",
                     c, e, d, lat, DEPTH_MAX, DEPTH_MAX + 1);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 8;
        logic [FV-1:0] vec [N];
        int eq_c[$], eq_e[$], eq_d[$];
        int ec, ee, ed, sent, got, last_done, cyc;
        build_example();
        for (int i = 0; i < N; i++) begin
            vec[i] = rand_feats();
            vec[i][7*FW +: FW] = ($urandom % 2 == 0) ? 8'hAF : 8'hB0;
        end
        sent = 0; got = 0; last_done = -10; cyc = 0;
        out_ready = 1'b1;
        while (got < N && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (out_valid === 1'b1) begin
                checks++;
                if (eq_c.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra_result: got result with nothing outstanding, want none");
                end else begin
                    ec = eq_c.pop_front(); ee = eq_e.pop_front(); ed = eq_d.pop_front();
                    if (int'(out_class) !== ec || int'(out_err) !== ee ||
                        int'(out_depth) !== ed) begin
                        errors++;
                        $display("FAIL b2b_result_%0d: got cls=%0d err=%0d dep=%0d, want %0d %0d %0d",
                                 got, out_class, out_err, out_depth, ec, ee, ed);
                    end
                end
                got++;
                last_done = cyc;
            end
            in_valid = (sent < N);
            if (sent < N) in_feats = vec[sent];
            if (in_ready === 1'b1 && sent < N) begin
                if (sent > 0) begin
                    checks++;
                    if (cyc !== last_done + 1) begin
                        errors++;
                        $display("FAIL b2b_gap_%0d: got accept cycle %0d, want %0d",
                                 sent, cyc, last_done + 1);
                    end
                end
                ref_walk(vec[sent], ec, ee, ed);
                eq_c.push_back(ec); eq_e.push_back(ee); eq_d.push_back(ed);
                sent++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got !== N) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, want %0d", got, N);
        end
    endtask

    initial begin
        test_reset();
        test_zero_table();
        test_example();
        test_bad_feat();
        test_cfg_with_accept();
        test_random();
        test_hold();
        test_reset_midwalk();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
